// File: rtl/mtime_timer.sv
// Machine timer: 1 MHz prescaler, 64-bit mtime with CLINT half-writes,
// and registered mtime >= mtimecmp interrupt request.
module mtime_timer #(
    parameter int FMAX_MHz = 27
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    input  logic        i_wr_valid,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wr_data,
    input  logic [63:0] i_mtimecmp,
    output logic [63:0] o_mtime,
    output logic        o_tick,
    output logic        o_mtip
);
    localparam int PW = $clog2(FMAX_MHz + 1);
    localparam logic [PW-1:0] PTERM = PW'(FMAX_MHz - 1);

    logic [PW-1:0] r_pcnt;
    logic [63:0]   r_mtime;
    logic          r_tick;
    logic          r_mtip;
    logic          w_term;
    logic [63:0]   w_mtime_wr;

    assign w_term = (r_pcnt == PTERM);

    // Selected half replaced, the other half kept; no carry between halves.
    assign w_mtime_wr = i_wr_hi ? {i_wr_data, r_mtime[31:0]}
                                : {r_mtime[63:32], i_wr_data};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pcnt  <= '0;
            r_mtime <= '0;
            r_tick  <= 1'b0;
            r_mtip  <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= i_mtimecmp);
            if (i_wr_valid) begin
                // A write restarts the period and suppresses any same-cycle increment.
                r_mtime <= w_mtime_wr;
                r_pcnt  <= '0;
                r_tick  <= 1'b0;
            end else if (i_halt) begin
                r_tick  <= 1'b0;
            end else if (w_term) begin
                r_pcnt  <= '0;
                r_mtime <= r_mtime + 64'd1;
                r_tick  <= 1'b1;
            end else begin
                r_pcnt  <= r_pcnt + 1'b1;
                r_tick  <= 1'b0;
            end
        end
    end

    assign o_mtime = r_mtime;
    assign o_tick  = r_tick;
    assign o_mtip  = r_mtip;
endmodule

// File: tb/tb_mtime_timer.sv
// Bench for mtime_timer: directed scenarios plus randomized traffic, checked
// every cycle against an elapsed-time model of the timer.
module tb_mtime_timer;
    localparam int F = 27;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_hi = 1'b0;
    logic [31:0] wr_data = '0;
    logic [63:0] mtimecmp = '1;
    logic [63:0] mtime;
    logic        tick;
    logic        mtip;

    always #5 clk = ~clk;

    mtime_timer #(.FMAX_MHz(F)) dut (
        .i_clk(clk), .i_reset(reset), .i_halt(halt), .i_wr_valid(wr_valid),
        .i_wr_hi(wr_hi), .i_wr_data(wr_data), .i_mtimecmp(mtimecmp),
        .o_mtime(mtime), .o_tick(tick), .o_mtip(mtip)
    );

    // Model: mtime = value at last write/reset + whole periods of running time since.
    logic [63:0]     m_base = '0;
    longint unsigned m_el = 0;
    logic            m_tick = 1'b0;
    logic            m_mtip = 1'b0;
    logic [63:0]     m_mtime;
    assign m_mtime = m_base + 64'(m_el / longint'(F));

    always @(posedge clk) begin
        logic [63:0] cur;
        cur = m_base + 64'(m_el / longint'(F));
        if (reset) begin
            m_base = '0; m_el = 0; m_tick = 1'b0; m_mtip = 1'b0;
        end else begin
            m_mtip = (cur >= mtimecmp);
            if (wr_valid) begin
                if (wr_hi) cur[63:32] = wr_data; else cur[31:0] = wr_data;
                m_base = cur; m_el = 0; m_tick = 1'b0;
            end else if (halt) begin
                m_tick = 1'b0;
            end else begin
                m_el   = m_el + 1;
                m_tick = ((m_el % longint'(F)) == 0);
            end
        end
    end

    int passed = 0;
    int total = 0;
    int tick_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("mtime_vs_model", mtime, m_mtime);
            chk("tick_vs_model", 64'(tick), 64'(m_tick));
            chk("mtip_vs_model", 64'(mtip), 64'(m_mtip));
            if (tick) tick_cnt++;
        end
    endtask

    task automatic wr(input logic hi, input logic [31:0] d);
        wr_valid = 1'b1; wr_hi = hi; wr_data = d;
        step(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        step(2);
        chk("reset_mtime", mtime, 64'd0);
        chk("reset_tick", 64'(tick), 64'd0);
        chk("reset_mtip", 64'(mtip), 64'd0);

        // Reset/count
        reset = 1'b0;
        tick_cnt = 0;
        step(F - 1);
        chk("first_inc_not_early", mtime, 64'd0);
        step(1);
        chk("first_inc", mtime, 64'd1);
        step(270 - F);
        chk("count_270", mtime, 64'd10);
        chk("tick_count_10", 64'(tick_cnt), 64'd10);
        chk("tick_at_inc", 64'(tick), 64'd1);
        chk("mtip_cmp_ones", 64'(mtip), 64'd0);

        // Interrupt
        wr(1'b0, 32'h0);
        wr(1'b1, 32'h0);
        mtimecmp = 64'd5;
        step(5 * F);
        chk("irq_mtime5", mtime, 64'd5);
        chk("irq_not_yet", 64'(mtip), 64'd0);
        step(1);
        chk("irq_rise", 64'(mtip), 64'd1);
        mtimecmp = 64'd100;
        step(1);
        chk("irq_fall", 64'(mtip), 64'd0);

        // Half writes
        wr(1'b0, 32'hFFFF_FFF0);
        wr(1'b1, 32'h1);
        wr(1'b1, 32'h2);
        chk("wr_hi", mtime, 64'h0000_0002_FFFF_FFF0);
        step(F - 1);
        chk("wr_hi_hold", mtime, 64'h0000_0002_FFFF_FFF0);
        step(1);
        chk("wr_hi_inc", mtime, 64'h0000_0002_FFFF_FFF1);
        wr(1'b0, 32'hFFFF_FFFF);
        chk("wr_lo_no_carry", mtime, 64'h0000_0002_FFFF_FFFF);
        step(F - 1);
        step(1);
        chk("inc_carry", mtime, 64'h0000_0003_0000_0000);

        // Collision on terminal prescaler cycle
        wr(1'b1, 32'h0);
        step(F - 1);
        wr(1'b0, 32'h10);
        chk("coll_mtime", mtime, 64'h10);
        chk("coll_tick", 64'(tick), 64'd0);
        step(F - 1);
        chk("coll_hold", mtime, 64'h10);
        step(1);
        chk("coll_next_inc", mtime, 64'h11);
        chk("coll_next_tick", 64'(tick), 64'd1);

        // Wrap
        wr(1'b0, 32'hFFFF_FFFF);
        wr(1'b1, 32'hFFFF_FFFF);
        step(F - 1);
        chk("wrap_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1);
        chk("wrap_zero", mtime, 64'd0);
        chk("wrap_mtip_old", 64'(mtip), 64'd1);
        step(1);
        chk("wrap_mtip_new", 64'(mtip), 64'd0);

        // Halt mid-period (prescaler at 10)
        step(9);
        halt = 1'b1;
        step(50);
        chk("halt_frozen", mtime, 64'd0);
        halt = 1'b0;
        step(F - 11);
        chk("halt_remaining", mtime, 64'd0);
        step(1);
        chk("halt_resume_inc", mtime, 64'd1);

        // Reset mid-operation
        mtimecmp = 64'd10;
        wr(1'b0, 32'd42);
        step(13);
        chk("pre_reset_mtime", mtime, 64'd42);
        chk("pre_reset_mtip", 64'(mtip), 64'd1);
        reset = 1'b1;
        step(1);
        chk("mid_reset_mtime", mtime, 64'd0);
        chk("mid_reset_tick", 64'(tick), 64'd0);
        chk("mid_reset_mtip", 64'(mtip), 64'd0);
        reset = 1'b0;
        step(F - 1);
        chk("post_reset_hold", mtime, 64'd0);
        step(1);
        chk("post_reset_inc", mtime, 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            halt     = ($urandom_range(0, 7) == 0);
            wr_valid = ($urandom_range(0, 29) == 0);
            wr_hi    = 1'($urandom_range(0, 1));
            wr_data  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 39) == 0)
                mtimecmp = m_mtime + 64'($urandom_range(0, 60)) - 64'd30;
            step(1);
        end
        reset = 1'b0; halt = 1'b0; wr_valid = 1'b0;
        step(2 * F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mtime_timer.md
# mtime_timer

Free-running machine timer feeding the CLINT MMIO block. Divides the core clock down to a 1 MHz tick and maintains the 64-bit `mtime` counter that the CLINT exposes for reads. Compares `mtime` against the `mtimecmp` value the CLINT produces and drives the registered machine-timer interrupt request (`mtip`) to the CSR/trap unit. Also accepts 32-bit half-writes to `mtime` forwarded from the CLINT address decode.

## Interface
- `FMAX_MHz`, 27, core clock frequency in MHz. Prescaler divide ratio; legal range 1..255.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `halt`  in  1  debug halt; freezes the prescaler and `mtime` while high.
- `wr_valid`  in  1  one-cycle write strobe for `mtime`.
- `wr_hi`  in  1  0 = write `mtime[31:0]`, 1 = write `mtime[63:32]`; sampled with `wr_valid`.
- `wr_data`  in  32  write data for the selected half.
- `mtimecmp`  in  64 (`UInt64`)  compare value from the CLINT.
- `mtime`  out  64 (`UInt64`)  current timer value, registered.
- `tick`  out  1  one-cycle pulse on each cycle in which `mtime` increments.
- `mtip`  out  1  machine timer interrupt pending, registered.

## Operation
- Prescaler `pcnt`:
  - `$clog2(FMAX_MHz+1)`-bit counter.
  - Counts 0..FMAX_MHz-1 on every non-halted cycle.
  - At the terminal count (`pcnt == FMAX_MHz-1`), wraps to 0 and `mtime <= mtime + 1`.
  - With `FMAX_MHz = 1`, `mtime` increments every non-halted cycle.
- `mtime` increment is unsigned modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
- Write (`wr_valid = 1`):
  - Replaces the selected 32-bit half with `wr_data` and leaves the other half unchanged.
  - Clears `pcnt` to 0, so a fresh full period starts.
  - Write has priority over an increment in the same cycle: no increment is applied, and `tick` stays 0 that cycle.
  - Low-half write does not carry into the high half.
  - A write is accepted while `halt = 1`.
- Halt: while `halt = 1` and `wr_valid = 0`, `pcnt`, `mtime` and `tick` hold (`tick = 0`). Counting resumes from the held `pcnt` value when `halt` deasserts.
- Interrupt: `mtip <= (mtime >= mtimecmp)`.
  - 64-bit unsigned compare using the registered `mtime` and the current `mtimecmp`.
  - Evaluated every cycle, including during halt.
  - Level-sensitive: `mtip` clears only when `mtimecmp` is raised above `mtime`, or `mtime` is rewritten below it.
- `tick` is registered: it is 1 in the cycle after the edge at which `mtime` incremented, i.e. coincident with the new `mtime` value.

## Timing
- Reset values: `mtime = 0`, `pcnt = 0`, `tick = 0`, `mtip = 0`.
- Reset mid-count discards the prescaler phase and any same-cycle write.
- First increment: `mtime` becomes 1 exactly FMAX_MHz rising edges after reset deasserts (halt low). The interval between successive increments is FMAX_MHz cycles.
- Write latency: the new `mtime` value is visible on the output 1 cycle after the `wr_valid` edge.
- Interrupt latency:
  - `mtip` is asserted 1 cycle after `mtime >= mtimecmp` first holds.
  - After a `mtimecmp` change, `mtip` reflects it 1 cycle later. The CLINT registers `mtimecmp`, so this is 2 cycles after the CLINT write strobe.
- With the CLINT's reset value of all ones for `mtimecmp`, `mtip` stays 0 until `mtime` reaches 2^64-1.
- No handshake back-pressure: writes are always accepted in the cycle presented.

## Test plan
- **Reset/count** (FMAX_MHz = 27, `mtimecmp` all ones): deassert reset, run 270 cycles -> `mtime == 10`; `tick` pulses exactly 10 times, 27 cycles apart; `mtip == 0`.
- **Interrupt:** `mtimecmp = 5`, count from 0 -> `mtip` rises 1 cycle after `mtime` becomes 5. Then set `mtimecmp = 100` -> `mtip` falls 1 cycle later.
- **Half write:**
  - `mtime = 0x0000_0001_FFFF_FFF0`, then write hi = 0x0000_0002 -> `mtime == 0x0000_0002_FFFF_FFF0` next cycle, and the next increment occurs 27 cycles later.
  - Write lo = 0xFFFF_FFFF, then one period elapses -> `mtime` becomes 0x0000_0003_0000_0000, confirming the increment carries into the high half.
- **Collision:** assert `wr_valid` (lo, data 0x10) on the terminal prescaler cycle -> `mtime == 0x10`, no increment, `tick = 0`, and the next tick comes 27 cycles later.
- **Wrap/halt:**
  - Preload `mtime = 2^64-1` -> after one period `mtime == 0` and `mtip` follows the compare.
  - Assert `halt` for 50 cycles mid-period -> `mtime` and `pcnt` are frozen; after release, the remaining cycles of the period complete before the increment.
- **Reset mid-operation:** pulse `reset` with `pcnt = 13`, `mtime = 42` and `mtip = 1` -> next cycle all outputs are 0, and the next increment occurs 27 cycles after reset deasserts.
